// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port 0 is the core load/store port and port 1 is the host/debug port. Only one
// transaction is outstanding at a time: IDLE picks a winner, ISSUE drives the
// memory for one cycle, and WAIT counts the read latency until load data returns.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority on a
// simultaneous request. When it is undefined the ports alternate round-robin.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   req/we/addr/wdata/be 0,1  requester command fields, held stable until gnt
//   gnt0, gnt1                one-cycle grant pulse in the issue cycle
//   rvalid0/1, rdata0/1       one-cycle load return; the non-winner rdata is 0
//   mem_en/we/addr/wdata/be   memory command; en, we and be are active only in ISSUE
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } xact_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    xact_t            xact_q;
    xact_t            xact_sel;
    logic             win_q;
    logic             win_sel;
    logic             any_req;
    logic             accept;

    assign any_req = req0 | req1;
    assign accept  = (state == IDLE) && any_req;

    // Winner selection: a single requester always wins.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 has fixed priority, so there is no last-granted pointer.
    assign win_sel = ~req0;
`else
    logic last_q;

    // Tracks the last granted port. It resets to port 1, so port 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= win_sel;
        end
    end

    assign win_sel = (req0 & req1) ? ~last_q : ~req0;
`endif

    // Mux the winning port's command fields.
    always_comb begin
        xact_sel = '0;
        if (win_sel) begin
            xact_sel.we    = we1;
            xact_sel.addr  = addr1;
            xact_sel.wdata = wdata1;
            xact_sel.be    = be1;
        end else begin
            xact_sel.we    = we0;
            xact_sel.addr  = addr0;
            xact_sel.wdata = wdata0;
            xact_sel.be    = be0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = xact_q.we ? IDLE : WAIT;
            WAIT:    if (cnt == CNT_W'(MEM_LAT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter. It is 1 in the first WAIT cycle, so it equals MEM_LAT
    // exactly MEM_LAT cycles after the issue cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_nxt == WAIT) begin
            cnt <= (state == ISSUE) ? CNT_W'(1) : cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Latched transaction and winner. These hold until the next acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xact_q <= '0;
            win_q  <= 1'b0;
        end else if (accept) begin
            xact_q <= xact_sel;
            win_q  <= win_sel;
        end
    end

    // Output decode from state and the latched fields.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = xact_q.addr;
        mem_wdata = xact_q.wdata;
        case (state)
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = xact_q.we;
                mem_be = xact_q.be;
                gnt0   = ~win_q;
                gnt1   = win_q;
            end
            WAIT: begin
                if (cnt == CNT_W'(MEM_LAT)) begin
                    // Load data passes straight through from the memory.
                    rvalid0 = ~win_q;
                    rvalid1 = win_q;
                    rdata0  = win_q ? '0 : mem_rdata;
                    rdata1  = win_q ? mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Instance u_dut (MEM_LAT=2) has a small
// byte-enabled memory model behind it. Instance u_lat4 (MEM_LAT=4) is used only
// for the reset-during-WAIT scenario.
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic        b_req0, b_req1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_mem_en, b_mem_we;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [3:0]  b_mem_be;

    int n_tests;
    int n_fail;

    dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .be0       (be0),
        .be1       (be1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(4), .ADDR_W(8)) u_lat4 (
        .clk       (clk),
        .rst       (rst),
        .req0      (b_req0),
        .req1      (b_req1),
        .we0       (1'b0),
        .we1       (1'b0),
        .addr0     (8'h20),
        .addr1     (8'h24),
        .wdata0    (32'h0),
        .wdata1    (32'h0),
        .be0       (4'hF),
        .be1       (4'hF),
        .gnt0      (b_gnt0),
        .gnt1      (b_gnt1),
        .rvalid0   (b_rvalid0),
        .rvalid1   (b_rvalid1),
        .rdata0    (b_rdata0),
        .rdata1    (b_rdata1),
        .mem_en    (b_mem_en),
        .mem_we    (b_mem_we),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_be    (b_mem_be),
        .mem_rdata (32'hDEADBEEF)
    );

    always #5 clk = ~clk;

    // Memory model: byte-enabled writes; read data appears LAT cycles after mem_en.
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:LAT-1];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h48656C6C;
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= 32'h0;
        end else begin
            if (mem_en && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'h0;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign mem_rdata = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        logic seen;
        n_tests = 0;
        n_fail  = 0;
        clk = 0; rst = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
        b_req0 = 0; b_req1 = 0;

        // Outputs while held in reset
        tick(); tick();
        check("rst_gnt0", 32'(gnt0), 32'h0);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        check("rst_rvalid0", 32'(rvalid0), 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        rst = 1;
        tick();

        // Store on port 0
        req0 = 1; we0 = 1; addr0 = 8'h0C; wdata0 = 32'h42796520; be0 = 4'hF;
        tick();
        check("st_gnt0", 32'(gnt0), 32'h1);
        check("st_gnt1", 32'(gnt1), 32'h0);
        check("st_mem_en", 32'(mem_en), 32'h1);
        check("st_mem_we", 32'(mem_we), 32'h1);
        check("st_mem_addr", 32'(mem_addr), 32'h0C);
        check("st_mem_wdata", mem_wdata, 32'h42796520);
        check("st_mem_be", 32'(mem_be), 32'hF);
        check("st_rvalid0", 32'(rvalid0), 32'h0);
        req0 = 0; we0 = 0;
        tick();
        check("st_idle_gnt0", 32'(gnt0), 32'h0);
        check("st_idle_mem_en", 32'(mem_en), 32'h0);
        check("st_idle_mem_we", 32'(mem_we), 32'h0);
        check("st_idle_mem_be", 32'(mem_be), 32'h0);
        check("st_idle_addr_hold", 32'(mem_addr), 32'h0C);
        check("st_idle_rvalid0", 32'(rvalid0), 32'h0);

        // Load on port 0 returns after exactly 2 cycles
        req0 = 1; we0 = 0; addr0 = 8'h00;
        tick();
        check("ld_gnt0", 32'(gnt0), 32'h1);
        check("ld_mem_we", 32'(mem_we), 32'h0);
        req0 = 0;
        tick();
        check("ld_w1_rvalid0", 32'(rvalid0), 32'h0);
        tick();
        check("ld_w2_rvalid0", 32'(rvalid0), 32'h1);
        check("ld_w2_rdata0", rdata0, 32'h48656C6C);
        check("ld_w2_rdata1", rdata1, 32'h0);
        check("ld_w2_rvalid1", 32'(rvalid1), 32'h0);
        tick();
        check("ld_done_rvalid0", 32'(rvalid0), 32'h0);

        // Load on port 1 reads back the stored word
        req1 = 1; we1 = 0; addr1 = 8'h0C;
        tick();
        check("ld1_gnt1", 32'(gnt1), 32'h1);
        check("ld1_gnt0", 32'(gnt0), 32'h0);
        req1 = 0;
        tick();
        check("ld1_w1_rvalid1", 32'(rvalid1), 32'h0);
        tick();
        check("ld1_w2_rvalid1", 32'(rvalid1), 32'h1);
        check("ld1_w2_rdata1", rdata1, 32'h42796520);
        check("ld1_w2_rdata0", rdata0, 32'h0);
        tick();

        // Both ports request stores continuously
        req0 = 1; we0 = 1; addr0 = 8'h04; wdata0 = 32'hAAAA0000; be0 = 4'hF;
        req1 = 1; we1 = 1; addr1 = 8'h08; wdata1 = 32'hBBBB1111; be1 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            check($sformatf("rr%0d_gnt0", i), 32'(gnt0), 32'(exp0));
            check($sformatf("rr%0d_gnt1", i), 32'(gnt1), 32'(!exp0));
            check($sformatf("rr%0d_wdata", i), mem_wdata, exp0 ? 32'hAAAA0000 : 32'hBBBB1111);
            if (i == 3) begin
                req0 = 0; req1 = 0;
            end
            tick();
            check($sformatf("rr%0d_gap_en", i), 32'(mem_en), 32'h0);
        end

        // Port 1 request raised during port 0 load WAIT
        req0 = 1; we0 = 0; addr0 = 8'h00;
        tick();
        check("wt_gnt0", 32'(gnt0), 32'h1);
        req0 = 0;
        tick();
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 32'h12345678; be1 = 4'h3;
        check("wt_w1_gnt1", 32'(gnt1), 32'h0);
        tick();
        check("wt_w2_rvalid0", 32'(rvalid0), 32'h1);
        check("wt_w2_rdata0", rdata0, 32'h48656C6C);
        check("wt_w2_gnt1", 32'(gnt1), 32'h0);
        tick();
        check("wt_idle_gnt1", 32'(gnt1), 32'h0);
        tick();
        check("wt_gnt1", 32'(gnt1), 32'h1);
        check("wt_mem_be", 32'(mem_be), 32'h3);
        check("wt_mem_addr", 32'(mem_addr), 32'h10);
        req1 = 0;
        tick();

        // Request dropped before the sampling edge gets no grant
        req0 = 1; we0 = 1;
        #3;
        req0 = 0;
        tick();
        check("cancel_gnt0", 32'(gnt0), 32'h0);
        check("cancel_mem_en", 32'(mem_en), 32'h0);

        // A lone request on the last-granted port still wins
        req1 = 1; we1 = 1; addr1 = 8'h14; wdata1 = 32'h0BADF00D; be1 = 4'hF;
        tick();
        check("single_gnt1", 32'(gnt1), 32'h1);
        check("single_gnt0", 32'(gnt0), 32'h0);
        req1 = 0;
        tick();

        // MEM_LAT=4: reset during WAIT clears outputs asynchronously and abandons the load
        b_req0 = 1;
        tick();
        check("b_gnt0", 32'(b_gnt0), 32'h1);
        b_req0 = 0;
        tick();
        tick();
        check("b_wait_addr", 32'(b_mem_addr), 32'h20);
        #2;
        rst = 0;
        #1;
        check("b_rst_gnt0", 32'(b_gnt0), 32'h0);
        check("b_rst_rvalid0", 32'(b_rvalid0), 32'h0);
        check("b_rst_mem_en", 32'(b_mem_en), 32'h0);
        check("b_rst_mem_addr", 32'(b_mem_addr), 32'h0);
        check("b_rst_rdata0", b_rdata0, 32'h0);
        tick();
        rst = 1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | b_rvalid0 | b_rvalid1;
        end
        check("b_no_rvalid", 32'(seen), 32'h0);
        b_req0 = 1; b_req1 = 1;
        tick();
        check("b_post_gnt0", 32'(b_gnt0), 32'h1);
        check("b_post_gnt1", 32'(b_gnt1), 32'h0);
        b_req0 = 0; b_req1 = 0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
